// File: rtl/mcs4_rom_fetch_ctrl_if.sv
// Requester handshake and MCS-4 control lines of the ROM fetch controller.
// The controller binds to the master modport; requesters and bus devices take the slave view.
interface mcs4_rom_fetch_ctrl_if;
    logic        req0;
    logic [11:0] addr0;
    logic        req1;
    logic [11:0] addr1;
    logic        ack0;
    logic        ack1;
    logic [7:0]  rdata;
    logic        sync;
    logic        cm;
    logic        busy;

    modport master (
        input  req0, addr0, req1, addr1,
        output ack0, ack1, rdata, sync, cm, busy
    );

    modport slave (
        output req0, addr0, req1, addr1,
        input  ack0, ack1, rdata, sync, cm, busy
    );
endinterface

// File: rtl/mcs4_rom_fetch_ctrl.sv
// Two-requester round-robin ROM fetch controller driving an MCS-4 4001 bus cycle
// (SYNC, A1-A3, M1-M2, X1-X2), each phase PHASE_DIV clocks long.
module mcs4_rom_fetch_ctrl #(
    parameter int unsigned PHASE_DIV = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    mcs4_rom_fetch_ctrl_if.master        bus,
    inout  wire  [3:0]                   data
);

    localparam logic [3:0] S_IDLE = 4'd0;
    localparam logic [3:0] S_SYNC = 4'd1;
    localparam logic [3:0] S_A1   = 4'd2;
    localparam logic [3:0] S_A2   = 4'd3;
    localparam logic [3:0] S_A3   = 4'd4;
    localparam logic [3:0] S_M1   = 4'd5;
    localparam logic [3:0] S_M2   = 4'd6;
    localparam logic [3:0] S_X1   = 4'd7;
    localparam logic [3:0] S_X2   = 4'd8;

    localparam logic [3:0] DIV_LAST = 4'(PHASE_DIV - 1);

    logic [3:0]  state_q, state_d;
    logic [3:0]  div_q, div_d;
    logic [11:0] addr_q, addr_d;
    logic        gnt_q, gnt_d;
    logic        prio_q, prio_d;
    logic        pend_q, pend_d;
    logic [7:0]  rbuf_q, rbuf_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        ack0_q, ack0_d;
    logic        ack1_q, ack1_d;

    logic        phase_end, x2_end;
    logic        r0, r1, any_req, win, do_grant;
    logic        drv_en;
    logic [3:0]  drv_val;

    // The grantee's own req is masked at its X2 decision: its ack is about to issue.
    always_comb begin
        phase_end = (div_q == DIV_LAST);
        x2_end    = (state_q == S_X2) && phase_end;
        r0        = bus.req0 && !(x2_end && !gnt_q);
        r1        = bus.req1 && !(x2_end && gnt_q);
        any_req   = r0 || r1;
        win       = (r0 && r1) ? prio_q : r1;
        do_grant  = any_req && (((state_q == S_IDLE) && !pend_q) || x2_end);
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        addr_d  = addr_q;
        gnt_d   = gnt_q;
        prio_d  = prio_q;
        pend_d  = pend_q;
        rbuf_d  = rbuf_q;
        rdata_d = rdata_q;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        if (state_q == S_IDLE) begin
            div_d = '0;
            if (pend_q) begin
                pend_d  = 1'b0;
                state_d = S_SYNC;
            end else if (do_grant) begin
                pend_d = 1'b1;
            end
        end else if (!phase_end) begin
            div_d = div_q + 4'd1;
        end else begin
            div_d = '0;
            case (state_q)
                S_SYNC: state_d = S_A1;
                S_A1:   state_d = S_A2;
                S_A2:   state_d = S_A3;
                S_A3:   state_d = S_M1;
                S_M1: begin
                    rbuf_d[7:4] = data;
                    state_d     = S_M2;
                end
                S_M2: begin
                    rbuf_d[3:0] = data;
                    state_d     = S_X1;
                end
                S_X1:   state_d = S_X2;
                S_X2: begin
                    rdata_d = rbuf_q;
                    ack0_d  = !gnt_q;
                    ack1_d  = gnt_q;
                    state_d = any_req ? S_SYNC : S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
        if (do_grant) begin
            gnt_d  = win;
            prio_d = !win;
            addr_d = win ? bus.addr1 : bus.addr0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            addr_q  <= '0;
            gnt_q   <= 1'b0;
            prio_q  <= 1'b0;
            pend_q  <= 1'b0;
            rbuf_q  <= '0;
            rdata_q <= '0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            addr_q  <= addr_d;
            gnt_q   <= gnt_d;
            prio_q  <= prio_d;
            pend_q  <= pend_d;
            rbuf_q  <= rbuf_d;
            rdata_q <= rdata_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
        end
    end

    always_comb begin
        drv_en = (state_q == S_A1) || (state_q == S_A2) || (state_q == S_A3);
        case (state_q)
            S_A1:    drv_val = addr_q[3:0];
            S_A2:    drv_val = addr_q[7:4];
            default: drv_val = addr_q[11:8];
        endcase
    end

    assign data      = drv_en ? drv_val : 4'bzzzz;
    assign bus.sync  = (state_q == S_SYNC);
    assign bus.cm    = (state_q == S_A3);
    assign bus.busy  = (state_q != S_IDLE);
    assign bus.ack0  = ack0_q;
    assign bus.ack1  = ack1_q;
    assign bus.rdata = rdata_q;

endmodule

// File: doc/mcs4_rom_fetch_ctrl.md
MCS4_ROM_FETCH_CTRL -- requirements
Module: mcs4_rom_fetch_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; all state SHALL update on the rising edge of clk.
REQ-002 Parameter PHASE_DIV, default 1, SHALL set the number of clk cycles per bus phase; the legal range is 1..15.
REQ-003 Port clk, input, 1 bit: system clock.
REQ-004 Port rst, input, 1 bit: asynchronous reset, active low.
REQ-005 Port req0, input, 1 bit: fetch request from requester 0 (CPU fetch).
REQ-006 Port addr0, input, 12 bits: ROM byte address for requester 0.
REQ-007 Port req1, input, 1 bit: fetch request from requester 1 (debug port).
REQ-008 Port addr1, input, 12 bits: ROM byte address for requester 1.
REQ-009 Port ack0, output, 1 bit: one-clk completion pulse to requester 0.
REQ-010 Port ack1, output, 1 bit: one-clk completion pulse to requester 1.
REQ-011 Port rdata, output, 8 bits: fetched byte, {M1 nibble, M2 nibble}.
REQ-012 Port data, inout, 4 bits: MCS-4 data bus.
REQ-013 Port sync, output, 1 bit: instruction-cycle sync to the 4001 devices.
REQ-014 Port cm, output, 1 bit: ROM memory-control line.
REQ-015 Port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-016 The state machine SHALL have the states IDLE, SYNC, A1, A2, A3, M1, M2, X1 and X2; each non-IDLE state SHALL last exactly PHASE_DIV clk cycles.
REQ-017 In IDLE, if any request is high, the block SHALL grant one requester on that edge, latch its address, and enter SYNC on the next clk.
REQ-018 Arbitration SHALL be round-robin: when both requests are high, the requester not granted last wins; after reset, requester 0 wins first.
REQ-019 The block SHALL drive sync high only during SYNC and low in all other states.
REQ-020 The block SHALL drive data with the latched address during the address phases:
- A1: addr[3:0]
- A2: addr[7:4]
- A3: addr[11:8]
REQ-021 The block SHALL drive cm high only during A3.
REQ-022 data SHALL be high-impedance in IDLE, SYNC, M1, M2, X1 and X2.
REQ-023 The block SHALL sample data on the last clk of M1 into rdata[7:4] and on the last clk of M2 into rdata[3:0].
REQ-024 On the last clk of X2, the block SHALL pulse the granted requester's ack high for exactly one clk, starting on the following clk.
- rdata SHALL be valid on that clk and held until the next ack.
REQ-025 On the last clk of X2, the block SHALL re-arbitrate: with a request pending it SHALL go directly to SYNC (back-to-back, no IDLE cycle); otherwise it SHALL go to IDLE.
REQ-026 For a requester granted back-to-back, the ack SHALL coincide with the first SYNC clk of the next cycle.
REQ-027 A requester SHALL hold req until its ack; the arbiter SHALL ignore the req of the requester currently holding the grant during its own X2 decision only if that requester's ack is being issued (no double grant from a stale req).
REQ-028 Request deassertion or address change mid-cycle SHALL NOT affect the cycle in progress; the latched address SHALL be used.
REQ-029 With PHASE_DIV=1, ack SHALL rise 9 clk after the edge that granted in IDLE (fixed latency of 8 phases plus 1).
REQ-030 ack0 and ack1 SHALL never be high on the same clk.

Reset
REQ-031 While rst is low, the block SHALL hold the following, asynchronously:
- state = IDLE
- data = high-impedance
- sync, cm, ack0, ack1, busy = 0
- rdata = 8'h00
- round-robin pointer selects requester 0
REQ-032 Reset asserted mid-cycle SHALL abort the cycle with no ack issued.
REQ-033 After rst rises, the first grant SHALL occur no earlier than the first rising clk edge.

Verification
REQ-034 Single fetch: PHASE_DIV=1, req0=1, addr0=12'h2A5, ROM byte 8'hD3 → bench observes the following, then ack0 one clk with rdata=8'hD3, busy falls.
- sync high for 1 clk
- data=5, A, 2 on A1..A3
- cm high on A3
REQ-035 Contention: req0 and req1 both high from reset → first grant to 0, second back-to-back grant to 1 with no IDLE clk between cycles, then 0 again; no two acks on the same clk.
REQ-036 PHASE_DIV=3: single fetch of addr1=12'hFFF → each phase lasts 3 clk, sync high for 3 clk, and ack1 rises 25 clk after the grant edge.
REQ-037 Reset mid-cycle: rst low during M1 → data hi-Z, sync/cm/ack low immediately, rdata=8'h00, no ack after release; a new req0 then completes normally.
REQ-038 Mid-cycle change: addr0 changed from 12'h010 to 12'h020 during A2 → bus still shows nibbles 0, 1, 0, and rdata reflects ROM[12'h010].
